// File: rtl/pupil_pkg.sv
// rtl/pupil_pkg.sv - shared state encoding and default geometry for the pupil bbox locator
// Purpose: frame FSM state type and default parameter values used by the locator and its
//          raster position counter.
// Contents: state_t {WAIT_SOF, ACCUM, REPORT}; *_DEF constants for image size, widths,
//           foreground code and minimum pixel count.
package pupil_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    REPORT   = 2'd2
  } state_t;

  localparam int         IMG_W_DEF    = 640;
  localparam int         IMG_H_DEF    = 480;
  localparam int         XW_DEF       = 10;
  localparam int         YW_DEF       = 10;
  localparam int         CW_DEF       = 19;
  localparam logic [7:0] FG_VALUE_DEF = 8'hFF;
  localparam int         MIN_PIX_DEF  = 16;

endpackage

// File: rtl/vid_pos_counter.sv
// rtl/vid_pos_counter.sv - raster x/y tracker with frame and line edge detection
// Purpose: derives the current pixel coordinate from the active-pixel qualifier and
//          flags frame start (vsync rise) and line end (en fall).
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   en         active-pixel qualifier
//   vsyn       frame sync, rising edge marks a frame boundary
//   x, y       coordinate of the pixel presented this cycle (saturating)
//   sof_ev     vsync rising edge this cycle (combinational)
//   eol_ev     en falling edge this cycle (combinational)
module vid_pos_counter
  import pupil_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vsyn,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof_ev,
  output logic          eol_ev
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic en_d;
  logic vs_d;

  assign sof_ev = vsyn & ~vs_d;
  assign eol_ev = en_d & ~en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      en_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      vs_d <= vsyn;
      if (sof_ev) begin
        // A line straddling the frame boundary belongs to the old frame, so the
        // en history is dropped too; otherwise its falling edge would bump y of
        // the new frame to 1 before the first real line.
        x    <= '0;
        y    <= '0;
        en_d <= 1'b0;
      end else begin
        en_d <= en;
        if (en) begin
          if (x != X_LAST) x <= x + 1'b1;
        end else if (eol_ev) begin
          x <= '0;
          if (y != Y_LAST) y <= y + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pupil_bbox_locator.sv
// rtl/pupil_bbox_locator.sv - per-frame bounding box, centre and count of foreground pixels
// Purpose: accumulates the bounding box and pixel count of foreground pixels over a frame
//          and publishes them with a one-cycle valid strobe after each frame boundary.
// Ports:
//   clk_i, a_rst_i        pixel clock, asynchronous active-high reset
//   i_hsyn, i_vsyn, i_en  line sync (pass-through), frame sync, active-pixel qualifier
//   i_binary              binary pixel, FG_VALUE marks foreground
//   o_hs, o_vs            syncs delayed one cycle
//   o_valid               one-cycle strobe, frame result updated
//   o_found               last frame had at least MIN_PIX foreground pixels
//   o_x_min..o_y_max      bounding box of last frame
//   o_cx, o_cy            box centre
//   o_count               foreground pixel count (saturating)
module pupil_bbox_locator
  import pupil_pkg::*;
#(
  parameter int         IMG_W    = IMG_W_DEF,
  parameter int         IMG_H    = IMG_H_DEF,
  parameter int         XW       = XW_DEF,
  parameter int         YW       = YW_DEF,
  parameter int         CW       = CW_DEF,
  parameter logic [7:0] FG_VALUE = FG_VALUE_DEF,
  parameter int         MIN_PIX  = MIN_PIX_DEF
) (
  input  logic          clk_i,
  input  logic          a_rst_i,
  input  logic          i_hsyn,
  input  logic          i_vsyn,
  input  logic          i_en,
  input  logic [7:0]    i_binary,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_valid,
  output logic          o_found,
  output logic [XW-1:0] o_x_min,
  output logic [XW-1:0] o_x_max,
  output logic [YW-1:0] o_y_min,
  output logic [YW-1:0] o_y_max,
  output logic [XW-1:0] o_cx,
  output logic [YW-1:0] o_cy,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_MINF = CW'(MIN_PIX);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sof_ev;
  logic          eol_ev;

  vid_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .XW   (XW),
    .YW   (YW)
  ) u_pos (
    .clk   (clk_i),
    .rst   (a_rst_i),
    .en    (i_en),
    .vsyn  (i_vsyn),
    .x     (x),
    .y     (y),
    .sof_ev(sof_ev),
    .eol_ev(eol_ev)
  );

  state_t        state;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;
  logic [CW-1:0] acc_cnt;

  logic          fg;
  logic [XW-1:0] nxt_xmin, nxt_xmax;
  logic [YW-1:0] nxt_ymin, nxt_ymax;
  logic [CW-1:0] nxt_cnt;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  assign fg = i_en && (i_binary == FG_VALUE);

  // Accumulators including this cycle's pixel. Latching outputs from these at the
  // boundary edge includes a pixel coincident with the vsync rise and makes the
  // result visible the very next cycle.
  always_comb begin
    nxt_xmin = acc_xmin;
    nxt_xmax = acc_xmax;
    nxt_ymin = acc_ymin;
    nxt_ymax = acc_ymax;
    nxt_cnt  = acc_cnt;
    if (fg) begin
      if (x < acc_xmin) nxt_xmin = x;
      if (x > acc_xmax) nxt_xmax = x;
      if (y < acc_ymin) nxt_ymin = y;
      if (y > acc_ymax) nxt_ymax = y;
      if (acc_cnt != CNT_MAX) nxt_cnt = acc_cnt + 1'b1;
    end
  end

  assign sum_x = {1'b0, nxt_xmin} + {1'b0, nxt_xmax};
  assign sum_y = {1'b0, nxt_ymin} + {1'b0, nxt_ymax};

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state    <= WAIT_SOF;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
      o_hs     <= 1'b0;
      o_vs     <= 1'b0;
      o_valid  <= 1'b0;
      o_found  <= 1'b0;
      o_x_min  <= '0;
      o_x_max  <= '0;
      o_y_min  <= '0;
      o_y_max  <= '0;
      o_cx     <= '0;
      o_cy     <= '0;
      o_count  <= '0;
    end else begin
      o_hs    <= i_hsyn;
      o_vs    <= i_vsyn;
      o_valid <= 1'b0;
      case (state)
        WAIT_SOF: begin
          if (sof_ev) begin
            state    <= ACCUM;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
            acc_cnt  <= '0;
          end
        end
        ACCUM: begin
          acc_xmin <= nxt_xmin;
          acc_xmax <= nxt_xmax;
          acc_ymin <= nxt_ymin;
          acc_ymax <= nxt_ymax;
          acc_cnt  <= nxt_cnt;
          if (sof_ev) begin
            state   <= REPORT;
            o_valid <= 1'b1;
            o_found <= (nxt_cnt >= CNT_MINF);
            o_x_min <= nxt_xmin;
            o_x_max <= nxt_xmax;
            o_y_min <= nxt_ymin;
            o_y_max <= nxt_ymax;
            o_cx    <= sum_x[XW:1];
            o_cy    <= sum_y[YW:1];
            o_count <= nxt_cnt;
          end
        end
        REPORT: begin
          // Restart the frame; a pixel arriving now is the new frame's first.
          state    <= ACCUM;
          acc_xmin <= fg ? x : '1;
          acc_xmax <= fg ? x : '0;
          acc_ymin <= fg ? y : '1;
          acc_ymax <= fg ? y : '0;
          acc_cnt  <= fg ? CW'(1) : '0;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_pupil_bbox_locator.sv
// tb/tb_pupil_bbox_locator.sv - randomized scoreboard bench for pupil_bbox_locator
module tb_pupil_bbox_locator;

  localparam int IMG_W   = 640;
  localparam int IMG_H   = 480;
  localparam int XW      = 10;
  localparam int YW      = 10;
  localparam int CW      = 19;
  localparam int MIN_PIX = 16;

  logic          clk = 1'b0;
  logic          a_rst_i;
  logic          i_hsyn, i_vsyn, i_en;
  logic [7:0]    i_binary;
  logic          o_hs, o_vs, o_valid, o_found;
  logic [XW-1:0] o_x_min, o_x_max, o_cx;
  logic [YW-1:0] o_y_min, o_y_max, o_cy;
  logic [CW-1:0] o_count;

  pupil_bbox_locator dut (
    .clk_i   (clk),
    .a_rst_i (a_rst_i),
    .i_hsyn  (i_hsyn),
    .i_vsyn  (i_vsyn),
    .i_en    (i_en),
    .i_binary(i_binary),
    .o_hs    (o_hs),
    .o_vs    (o_vs),
    .o_valid (o_valid),
    .o_found (o_found),
    .o_x_min (o_x_min),
    .o_x_max (o_x_max),
    .o_y_min (o_y_min),
    .o_y_max (o_y_max),
    .o_cx    (o_cx),
    .o_cy    (o_cy),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     xmin, xmax, ymin, ymax, cx, cy, count;
    int     found;
    longint cyc;
  } exp_t;

  exp_t   sbq[$];
  int     fx[$], fy[$];
  int     px[$], py[$];
  bit     armed;
  int     lines_done;
  int     rx0, rx1, ry0, ry1, pct;
  int     checks = 0, failures = 0;
  longint cyc = 0;
  logic   hs_q = 1'b0, vs_q = 1'b0, rst_q = 1'b1, prev_valid = 1'b0;
  exp_t   mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    hs_q  <= i_hsyn;
    vs_q  <= i_vsyn;
    rst_q <= a_rst_i;
  end

  // Monitor: passthrough syncs every cycle, frame results whenever o_valid is seen.
  always @(negedge clk) begin
    if (!a_rst_i && !rst_q) begin
      chk("o_hs", o_hs, hs_q);
      chk("o_vs", o_vs, vs_q);
    end
    if (o_valid === 1'b1) begin
      chk("valid_one_cycle", prev_valid, 0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got=1 expected=0 cyc=%0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("x_min", o_x_min, mon_e.xmin);
        chk("x_max", o_x_max, mon_e.xmax);
        chk("y_min", o_y_min, mon_e.ymin);
        chk("y_max", o_y_max, mon_e.ymax);
        chk("cx", o_cx, mon_e.cx);
        chk("cy", o_cy, mon_e.cy);
        chk("count", o_count, mon_e.count);
        chk("found", o_found, mon_e.found);
      end
    end
    prev_valid = o_valid;
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: bounding box of the recorded foreground coordinates of a frame.
  function automatic exp_t frame_result(input longint when);
    exp_t e;
    e.xmin  = (1 << XW) - 1;
    e.xmax  = 0;
    e.ymin  = (1 << YW) - 1;
    e.ymax  = 0;
    e.count = imin(fx.size(), (1 << CW) - 1);
    foreach (fx[i]) begin
      if (fx[i] < e.xmin) e.xmin = fx[i];
      if (fx[i] > e.xmax) e.xmax = fx[i];
      if (fy[i] < e.ymin) e.ymin = fy[i];
      if (fy[i] > e.ymax) e.ymax = fy[i];
    end
    e.cx    = (e.xmin + e.xmax) / 2;
    e.cy    = (e.ymin + e.ymax) / 2;
    e.found = (e.count >= MIN_PIX) ? 1 : 0;
    e.cyc   = when;
    return e;
  endfunction

  function automatic bit is_fg(input int col, input int row);
    if (col >= rx0 && col <= rx1 && row >= ry0 && row <= ry1) return 1'b1;
    foreach (px[i]) if (px[i] == col && py[i] == row) return 1'b1;
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      i_en     = 1'b0;
      i_hsyn   = 1'b0;
      i_binary = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int w, input int h);
    for (int row = 0; row < h; row++) begin
      for (int col = 0; col < w; col++) begin
        step();
        i_hsyn = 1'b0;
        i_en   = 1'b1;
        if (is_fg(col, row)) begin
          i_binary = 8'hFF;
          fx.push_back(imin(col, IMG_W - 1));
          fy.push_back(imin(row, IMG_H - 1));
        end else begin
          i_binary = 8'h00;
        end
      end
      step();
      i_en     = 1'b0;
      i_hsyn   = 1'b1;
      i_binary = 8'($urandom);
      idle(1 + $urandom_range(0, 2));
      lines_done++;
    end
  endtask

  // Frame boundary; with_px drives a foreground pixel in the vsync-rise cycle.
  task automatic vs_rise(input bit with_px);
    step();
    i_vsyn   = 1'b1;
    i_hsyn   = 1'b0;
    i_en     = with_px;
    i_binary = with_px ? 8'hFF : 8'($urandom);
    if (with_px) begin
      fx.push_back(0);
      fy.push_back(imin(lines_done, IMG_H - 1));
    end
    if (armed) sbq.push_back(frame_result(cyc + 1));
    fx.delete();
    fy.delete();
    armed      = 1'b1;
    lines_done = 0;
    for (int i = 0; i < int'($urandom_range(0, 2)) + 1; i++) begin
      step();
      i_en     = 1'b0;
      i_binary = 8'($urandom);
    end
    step();
    i_vsyn = 1'b0;
    idle(2);
  endtask

  task automatic clear_pattern();
    rx0 = 1;
    rx1 = 0;
    ry0 = 1;
    ry1 = 0;
    pct = 0;
    px.delete();
    py.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_found"}, o_found, 0);
    chk({tag, "_x_min"}, o_x_min, 0);
    chk({tag, "_x_max"}, o_x_max, 0);
    chk({tag, "_y_min"}, o_y_min, 0);
    chk({tag, "_y_max"}, o_y_max, 0);
    chk({tag, "_cx"}, o_cx, 0);
    chk({tag, "_cy"}, o_cy, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_hs"}, o_hs, 0);
    chk({tag, "_vs"}, o_vs, 0);
  endtask

  task automatic model_reset();
    fx.delete();
    fy.delete();
    armed      = 1'b0;
    lines_done = 0;
  endtask

  initial begin
    a_rst_i  = 1'b1;
    i_hsyn   = 1'b1;
    i_vsyn   = 1'b0;
    i_en     = 1'b0;
    i_binary = 8'h00;
    model_reset();
    clear_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    step();
    a_rst_i = 1'b0;
    i_hsyn  = 1'b0;
    idle(2);

    // Partial frame after reset is never reported; the next one is.
    px.push_back(2); py.push_back(1);
    px.push_back(5); py.push_back(3);
    send_frame(8, 4);
    vs_rise(0);
    send_frame(8, 4);
    vs_rise(0);

    // Solid 5x5 block.
    clear_pattern();
    rx0 = 10; rx1 = 14; ry0 = 6; ry1 = 10;
    send_frame(20, 20);
    vs_rise(0);

    // All background.
    clear_pattern();
    send_frame(12, 6);
    vs_rise(0);

    // Foreground pixel coincident with the vsync rise.
    clear_pattern();
    pct = 5;
    send_frame(10, 5);
    vs_rise(1);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      clear_pattern();
      pct = $urandom_range(0, 30);
      send_frame($urandom_range(4, 40), $urandom_range(2, 20));
      vs_rise(1'($urandom_range(0, 1)));
    end

    // Line longer than IMG_W with foreground on the last enable cycle.
    clear_pattern();
    px.push_back(IMG_W + 2); py.push_back(0);
    send_frame(IMG_W + 3, 1);
    vs_rise(0);

    // Reset in the middle of a line.
    clear_pattern();
    pct = 20;
    send_frame(10, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      i_en     = 1'b1;
      i_binary = 8'hFF;
    end
    step();
    a_rst_i = 1'b1;
    i_en    = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs_zero("midrst");
    step();
    a_rst_i = 1'b0;
    idle(2);
    send_frame(8, 3);
    vs_rise(0);
    clear_pattern();
    pct = 50;
    send_frame(16, 6);
    vs_rise(0);

    idle(5);
    chk("pending_results", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
